// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider states and divide-by-zero result.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam logic [ALU_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/sub_stage.sv
// Combinational (WIDTH+1)-bit trial subtractor for one restoring-division step.
module sub_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned FULL_W = WIDTH + 2;

  logic [FULL_W-1:0] w_full;
  logic              w_unused_msb;

  // A kept difference is always below the divisor, so bit WIDTH is never needed.
  assign w_full       = {1'b0, i_a} - {2'b00, i_b};
  assign o_diff       = w_full[WIDTH-1:0];
  assign o_borrow     = w_full[WIDTH+1];
  assign w_unused_msb = w_full[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, results held until the next accepted operation.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // Shift the quotient MSB into the partial remainder, then try to subtract.
  assign w_trial = {r_rem, r_q[WIDTH-1]};

  sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub_stage (
    .i_a      (w_trial),
    .i_b      (r_div),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_rem_next = w_borrow ? w_trial[WIDTH-1:0] : w_diff;
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};

  // Result registers are loaded on the edge entering FIN so they are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_div  <= divisor;
            r_q    <= dividend;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (divisor == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_remo  <= dividend;
              r_dz    <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_remo  <= w_rem_next;
            r_dz    <= 1'b0;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  // Last result the DUT should be showing between operations
  logic [31:0] g_q;
  logic [31:0] g_r;
  logic        g_dz;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endfunction

  // Called at a negedge with the DUT idle; drives start in this cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_k);
    logic [31:0] eq, er;
    logic        edz;
    int          lat, first_k, n_done, n_busy, n_dbl;
    logic        prev_done;
    model(a, b, eq, er, edz);
    lat = (b == 32'd0) ? 1 : 33;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    first_k = 0; n_done = 0; n_busy = 0; n_dbl = 0; prev_done = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        n_done++;
        if (first_k == 0) first_k = k;
        if (prev_done) n_dbl++;
      end
      prev_done = done;
      if (lat > 1 && k == lat - 1) begin
        chk("held_q", quotient, g_q);
        chk("held_r", remainder, g_r);
        chk("held_dz", div_by_zero, g_dz);
      end
      if (k == lat) begin
        chk("quot", quotient, eq);
        chk("rem", remainder, er);
        chk("dz", div_by_zero, edz);
        if (b != 32'd0) begin
          chk("ident", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
          chk("rem_lt", 64'(remainder < b), 64'd1);
        end
      end
      if (k == lat + 1) begin
        chk("busy_end", busy, 1'b0);
        chk("hold_q", quotient, eq);
      end
      if (k == 1) start = 1'b0;
      if (inj_k != 0 && k == inj_k) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      if (inj_k != 0 && k == inj_k + 1) start = 1'b0;
    end
    chk("latency", 64'(first_k), 64'(lat));
    chk("done_cnt", 64'(n_done), 64'd1);
    chk("done_dbl", 64'(n_dbl), 64'd0);
    chk("busy_cnt", 64'(n_busy), 64'(lat));
    g_q = eq; g_r = er; g_dz = edz;
  endtask

  initial begin
    int n_done_after, n_busy_after;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    g_q = '0; g_r = '0; g_dz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back in the first cycle after FIN
    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'd5, 32'd9, 0);
    run_op(32'd1234, 32'd0, 0);
    run_op(32'd100, 32'd7, 10);
    run_op(32'd50, 32'd5, 0);

    // Asynchronous reset in the middle of an operation
    start = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_dz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_done_after = 0; n_busy_after = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done_after++;
      if (busy === 1'b1) n_busy_after++;
    end
    chk("no_done_after_rst", 64'(n_done_after), 64'd0);
    chk("no_busy_after_rst", 64'(n_busy_after), 64'd0);
    g_q = '0; g_r = '0; g_dz = 1'b0;
    run_op(32'hDEAD_BEEF, 32'd3, 0);

    // Random sweep with a spread of operand magnitudes
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      run_op(ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
